// File: rtl/arbitro_mem_pkg.sv
// Shared definitions for the bancoMem two-port arbiter: bus widths and FSM encoding.
package arbitro_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } state_t;

endpackage

// File: rtl/arbitro_mem_if.sv
// Requester-side handshake bundle for both arbiter ports; master = requesters, slave = arbiter.
interface arbitro_mem_if
    import arbitro_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, addr1, wdata1,
        output gnt1, rvalid1, rdata1
    );

endinterface

// File: rtl/arbitro_rr.sv
// Combinational 2-way winner pick; winner is only meaningful when a request is present.
module arbitro_rr (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic rr_en,
    output logic winner
);

    // On a tie the port not granted last wins, unless fixed priority is selected.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = rr_en ? ~last : 1'b0;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_mem.sv
// Arbiter and sequencer sharing the single-port bancoMem between two requesters.
module arbitro_mem
    import arbitro_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    arbitro_mem_if.slave      bus,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] mem_dado,
    output logic              mem_lerMem,
    output logic              mem_EscreverMem,
    input  logic [DATA_W-1:0] mem_out
);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              win_q, win_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic              ler_q, ler_d, esc_q, esc_d;
    logic              winner;

    arbitro_rr u_rr (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_q),
        .rr_en  (RR_EN),
        .winner (winner)
    );

    // Next-state and next-output logic; every output is registered, so grants and
    // strobes for an access are computed while still in IDLE.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        win_d     = win_q;
        last_d    = last_q;
        addr_d    = addr_q;
        dado_d    = dado_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        ler_d     = 1'b0;
        esc_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win_d   = winner;
                    last_d  = winner;
                    we_d    = winner ? bus.we1    : bus.we0;
                    addr_d  = winner ? bus.addr1  : bus.addr0;
                    dado_d  = winner ? bus.wdata1 : bus.wdata0;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    esc_d   = we_d;
                    ler_d   = ~we_d;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                if (win_q) begin
                    rdata1_d  = mem_out;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_out;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset pointer to 1 so port 0 takes the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            win_q     <= 1'b0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            addr_q    <= '0;
            dado_q    <= '0;
            ler_q     <= 1'b0;
            esc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            win_q     <= win_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            addr_q    <= addr_d;
            dado_q    <= dado_d;
            ler_q     <= ler_d;
            esc_q     <= esc_d;
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign mem_endereco    = addr_q;
    assign mem_dado        = dado_q;
    assign mem_lerMem      = ler_q;
    assign mem_EscreverMem = esc_q;

endmodule

// File: tb/tb_arbitro_mem.sv
// Directed bench for arbitro_mem: one round-robin and one fixed-priority instance, each with a bancoMem model.
module tb_arbitro_mem;

    logic clock;
    logic reset;

    arbitro_mem_if bus_rr ();
    arbitro_mem_if bus_fp ();

    logic [7:0] rr_end, rr_dado, rr_out;
    logic       rr_ler, rr_esc;
    logic [7:0] fp_end, fp_dado, fp_out;
    logic       fp_ler, fp_esc;

    logic [7:0] mem_rr [256];
    logic [7:0] mem_fp [256];

    logic       preload_we;
    logic [7:0] preload_addr;
    logic [7:0] preload_data;

    int num_checks = 0;
    int num_fails  = 0;

    logic [1:0] rr_tbl [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0] fp_tbl [8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    arbitro_mem #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b1)) dut_rr (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus_rr),
        .mem_endereco    (rr_end),
        .mem_dado        (rr_dado),
        .mem_lerMem      (rr_ler),
        .mem_EscreverMem (rr_esc),
        .mem_out         (rr_out)
    );

    arbitro_mem #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b0)) dut_fp (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus_fp),
        .mem_endereco    (fp_end),
        .mem_dado        (fp_dado),
        .mem_lerMem      (fp_ler),
        .mem_EscreverMem (fp_esc),
        .mem_out         (fp_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // bancoMem models: synchronous write, read data registered one cycle after lerMem.
    always @(posedge clock) begin
        if (rr_esc) mem_rr[rr_end] <= rr_dado;
        else if (preload_we) mem_rr[preload_addr] <= preload_data;
        if (rr_ler) rr_out <= mem_rr[rr_end];
    end

    always @(posedge clock) begin
        if (fp_esc) mem_fp[fp_end] <= fp_dado;
        if (fp_ler) fp_out <= mem_fp[fp_end];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit fp, input bit port, input logic req, input logic we,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        if (!fp && !port) begin
            bus_rr.req0 = req; bus_rr.we0 = we; bus_rr.addr0 = addr; bus_rr.wdata0 = wdata;
        end else if (!fp && port) begin
            bus_rr.req1 = req; bus_rr.we1 = we; bus_rr.addr1 = addr; bus_rr.wdata1 = wdata;
        end else if (fp && !port) begin
            bus_fp.req0 = req; bus_fp.we0 = we; bus_fp.addr0 = addr; bus_fp.wdata0 = wdata;
        end else begin
            bus_fp.req1 = req; bus_fp.we1 = we; bus_fp.addr1 = addr; bus_fp.wdata1 = wdata;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        preload_we   = 1'b0;
        preload_addr = 8'd0;
        preload_data = 8'd0;
        applyStimulus(0, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0);
        applyStimulus(1, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(1, 1, 0, 0, 8'd0, 8'd0);

        #3;
        checkOutput("reset_rr_ctl", 32'({bus_rr.gnt0, bus_rr.gnt1, bus_rr.rvalid0, bus_rr.rvalid1, rr_ler, rr_esc}), 32'd0);
        checkOutput("reset_rr_data", 32'({rr_end, rr_dado, bus_rr.rdata0, bus_rr.rdata1}), 32'd0);
        checkOutput("reset_fp_ctl", 32'({bus_fp.gnt0, bus_fp.gnt1, bus_fp.rvalid0, bus_fp.rvalid1, fp_ler, fp_esc}), 32'd0);
        step();
        step();
        reset = 1'b0;

        // Single write from port 0.
        applyStimulus(0, 0, 1, 1, 8'd1, 8'd1);
        checkOutput("wr_gnt_before", 32'(bus_rr.gnt0), 32'd0);
        step();
        checkOutput("wr_gnt0", 32'({bus_rr.gnt1, bus_rr.gnt0}), 32'b01);
        checkOutput("wr_strobes", 32'({rr_esc, rr_ler}), 32'b10);
        checkOutput("wr_addr", 32'(rr_end), 32'd1);
        checkOutput("wr_data", 32'(rr_dado), 32'd1);
        applyStimulus(0, 0, 0, 1, 8'd1, 8'd1);
        step();
        checkOutput("wr_after_ctl", 32'({bus_rr.gnt0, rr_esc, rr_ler}), 32'd0);
        checkOutput("wr_addr_hold", 32'(rr_end), 32'd1);
        checkOutput("wr_mem", 32'(mem_rr[1]), 32'd1);
        step();
        checkOutput("wr_no_rvalid", 32'(bus_rr.rvalid0), 32'd0);

        // Read-back from port 0.
        applyStimulus(0, 0, 1, 0, 8'd1, 8'd0);
        step();
        checkOutput("rd_gnt0", 32'({bus_rr.gnt1, bus_rr.gnt0}), 32'b01);
        checkOutput("rd_strobes", 32'({rr_esc, rr_ler}), 32'b01);
        applyStimulus(0, 0, 0, 0, 8'd1, 8'd0);
        step();
        checkOutput("rd_resp_ctl", 32'({rr_ler, rr_esc, bus_rr.rvalid0}), 32'd0);
        step();
        checkOutput("rd_rvalid", 32'(bus_rr.rvalid0), 32'd1);
        checkOutput("rd_rdata", 32'(bus_rr.rdata0), 32'd1);
        step();
        checkOutput("rd_rvalid_pulse", 32'(bus_rr.rvalid0), 32'd0);
        checkOutput("rd_rdata_hold", 32'(bus_rr.rdata0), 32'd1);

        // Reset asserted while a read is in ACCESS.
        applyStimulus(0, 0, 1, 0, 8'd1, 8'd0);
        step();
        checkOutput("rst_pre_ler", 32'(rr_ler), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_mid_ctl", 32'({rr_ler, rr_esc, bus_rr.gnt0, bus_rr.rvalid0}), 32'd0);
        checkOutput("rst_mid_data", 32'({rr_end, rr_dado, bus_rr.rdata0}), 32'd0);
        applyStimulus(0, 0, 0, 0, 8'd0, 8'd0);
        step();
        step();
        checkOutput("rst_no_rvalid", 32'(bus_rr.rvalid0), 32'd0);
        reset = 1'b0;
        step();
        checkOutput("rst_idle", 32'({bus_rr.rvalid0, bus_rr.gnt0, rr_ler, rr_esc}), 32'd0);

        // Round-robin tie with both ports holding write requests.
        applyStimulus(0, 0, 1, 1, 8'd5, 8'h55);
        applyStimulus(0, 1, 1, 1, 8'd6, 8'h66);
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput("rr_gnt", 32'({bus_rr.gnt1, bus_rr.gnt0}), 32'(rr_tbl[i]));
            checkOutput("rr_gnt_excl", 32'(bus_rr.gnt0 & bus_rr.gnt1), 32'd0);
            if (i == 0) checkOutput("rr_addr0", 32'(rr_end), 32'd5);
            if (i == 2) checkOutput("rr_addr1", 32'(rr_end), 32'd6);
        end
        applyStimulus(0, 0, 0, 1, 8'd5, 8'h55);
        applyStimulus(0, 1, 0, 1, 8'd6, 8'h66);
        step();
        checkOutput("rr_mem5", 32'(mem_rr[5]), 32'h55);
        checkOutput("rr_mem6", 32'(mem_rr[6]), 32'h66);

        // Fixed priority: port 0 re-requests continuously.
        applyStimulus(1, 0, 1, 1, 8'h40, 8'h11);
        applyStimulus(1, 1, 1, 1, 8'h41, 8'h22);
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("fp_gnt", 32'({bus_fp.gnt1, bus_fp.gnt0}), 32'(fp_tbl[i]));
            if (i == 4) applyStimulus(1, 0, 0, 1, 8'h40, 8'h11);
            if (i == 6) applyStimulus(1, 1, 0, 1, 8'h41, 8'h22);
        end
        checkOutput("fp_mem40", 32'(mem_fp[8'h40]), 32'h11);
        checkOutput("fp_mem41", 32'(mem_fp[8'h41]), 32'h22);

        // Mixed ports: port 1 reads addr 9, port 0 writes it in the next arbitration.
        preload_addr = 8'd9;
        preload_data = 8'hA5;
        preload_we   = 1'b1;
        step();
        preload_we   = 1'b0;
        applyStimulus(0, 1, 1, 0, 8'd9, 8'd0);
        step();
        checkOutput("mx_gnt1", 32'({bus_rr.gnt1, bus_rr.gnt0}), 32'b10);
        checkOutput("mx_ler", 32'({rr_esc, rr_ler}), 32'b01);
        applyStimulus(0, 1, 0, 0, 8'd9, 8'd0);
        applyStimulus(0, 0, 1, 1, 8'd9, 8'h3C);
        step();
        checkOutput("mx_resp_gnt", 32'({bus_rr.gnt1, bus_rr.gnt0}), 32'b00);
        step();
        checkOutput("mx_rvalid1", 32'({bus_rr.rvalid1, bus_rr.rvalid0}), 32'b10);
        checkOutput("mx_rdata1", 32'(bus_rr.rdata1), 32'hA5);
        checkOutput("mx_gnt_wait", 32'(bus_rr.gnt0), 32'd0);
        step();
        checkOutput("mx_gnt0", 32'({bus_rr.gnt1, bus_rr.gnt0}), 32'b01);
        checkOutput("mx_esc", 32'({rr_esc, rr_ler}), 32'b10);
        checkOutput("mx_dado", 32'(rr_dado), 32'h3C);
        checkOutput("mx_rvalid_pulse", 32'(bus_rr.rvalid1), 32'd0);
        applyStimulus(0, 0, 0, 1, 8'd9, 8'h3C);
        step();
        checkOutput("mx_mem9", 32'(mem_rr[9]), 32'h3C);
        checkOutput("mx_rdata1_hold", 32'(bus_rr.rdata1), 32'hA5);
        checkOutput("mx_no_rvalid0", 32'(bus_rr.rvalid0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/arbitro_mem.md
Name: arbitro_mem

Overview:
- Two-port arbiter and sequencer for the single-port data memory bancoMem (8-bit address, 8-bit data, lerMem/EscreverMem strobes).
- Shares the memory between requester 0 (CPU load/store stage) and requester 1 (loader/debug port).
- Serialises accesses, drives the memory strobes for exactly one cycle per access, and returns read data with a valid pulse.

Parameters:
- ADDR_W, 8, address width; matches bancoMem endereco.
- DATA_W, 8, data width; matches bancoMem dado/out.
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, port 0 always wins.

Ports:
- clock  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 access request; held until gnt0 is seen.
- we0  input  1  port 0 access type: 1 = write, 0 = read; stable while req0 is high.
- addr0  input  ADDR_W  port 0 address; stable while req0 is high.
- wdata0  input  DATA_W  port 0 write data; stable while req0 is high.
- gnt0  output  1  one-cycle grant pulse for port 0.
- rvalid0  output  1  one-cycle pulse: rdata0 holds read result.
- rdata0  output  DATA_W  port 0 read data; registered, held until the next port 0 read.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_endereco  output  ADDR_W  address to bancoMem.
- mem_dado  output  DATA_W  write data to bancoMem.
- mem_lerMem  output  1  read strobe to bancoMem.
- mem_EscreverMem  output  1  write strobe to bancoMem.
- mem_out  input  DATA_W  bancoMem read data; valid the cycle after a lerMem cycle.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- Reset (asynchronous, immediate):
  - state = IDLE.
  - gnt*, rvalid*, mem_lerMem, mem_EscreverMem = 0.
  - mem_endereco, mem_dado, rdata0, rdata1 = 0.
  - last-winner pointer = 1, so port 0 wins the first tie.
- IDLE, cycle N:
  - If any req is high, pick a winner; latch its addr, wdata and we; record the winner; go to ACCESS.
  - Requests are sampled only in IDLE.
  - A request deasserted before its gnt is simply not served.
- ACCESS, cycle N+1:
  - Assert gnt of the winner only.
  - Drive mem_endereco and mem_dado from the latched values.
  - If write: assert mem_EscreverMem and go to IDLE.
  - If read: assert mem_lerMem and go to RESP.
  - Exactly one strobe is high, for exactly one cycle.
- RESP, cycle N+2:
  - Strobes = 0.
  - Capture mem_out into rdata of the winner at the end of the cycle.
  - Go to IDLE.
  - rvalid of the winner pulses in N+3.
- Latency:
  - Write: request seen in N, written at the end of N+1; next arbitration in N+2.
  - Read: rvalid in N+3; the IDLE arbitration in N+3 may proceed in parallel with the rvalid pulse.
- Requester contract: drop req the cycle after seeing gnt. If req is still high in the next IDLE, it is treated as a new request.
- Tie handling:
  - RR_EN=1: the port not granted last wins.
  - RR_EN=0: port 0 wins.
  - A single requester always wins, whatever the pointer.
- Outside ACCESS:
  - Strobes are 0.
  - mem_endereco and mem_dado hold their last values.
  - gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.
- The pointer updates only on a grant.
- The address is passed through unchanged; no wrap or range checks (256 locations).
- Reset mid-operation: strobes drop immediately, the in-flight read is discarded (no rvalid), and a write in ACCESS is not guaranteed.

Decomposition:
- Shared package arbitro_mem_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - ADDR_W and DATA_W defaults.
- One sub-module, arbitro_rr: 2-way winner pick.
  - Inputs: req0, req1, last, rr_en.
  - Output: winner.
  - Purely combinational; the last pointer register stays in arbitro_mem.

Test Plan:
- Reset: assert reset mid-ACCESS -> strobes 0 in the same cycle, state IDLE, all outputs 0, no rvalid.
- Single write: req0=1, we0=1, addr0=8'd1, wdata0=8'd1 -> gnt0 and mem_EscreverMem high exactly 1 cycle with mem_endereco=1, mem_dado=1; no rvalid0.
- Read-back: after the write above, req0=1, we0=0, addr0=1 -> mem_lerMem for 1 cycle, then rvalid0=1 exactly 3 cycles after request sampling, rdata0=8'd1.
- Round-robin tie: req0 and req1 both held through 4 grants (writes, addr 5 and 6) -> grant order 0,1,0,1; never both gnt high.
- Fixed priority: RR_EN=0, both requesting continuously, port 0 re-requests immediately -> port 0 granted every arbitration, port 1 only once req0 drops.
- Mixed ports: port 1 reads addr 8'd9, preloaded with 8'hA5, while port 0 writes addr 8'd9 8'h3C in the next arbitration -> rvalid1 with rdata1=8'hA5, then memory holds 8'h3C; rdata1 is held at 8'hA5 afterwards.
